// File: rtl/mem_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_seq_pkg
//  Description : Shared types and constants for the memory access sequencer
//                and the control FSM instruction decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_FAULT   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam int LAT_MAX = 15;
    localparam int CNT_W   = 4;

    // Instruction field positions, shared with the control FSM decode
    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_seq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_seq_counter
//  Description : Loadable down-counter timing the memory read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_seq_counter
    import mem_seq_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset_signal,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             is_one
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge Clk or negedge Reset_signal) begin
        if (!Reset_signal) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign is_one = (r_count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_sequencer
//  Description : Req/Done memory access sequencer for the multicycle datapath;
//                selects PC/ALUOut, waits out read latency, loads IR or MDR.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_sequencer
    import mem_seq_pkg::*;
#(
    parameter int LAT = 2
)(
    input  logic        Clk,
    input  logic        Reset_signal,
    input  logic        Req,
    input  logic        Wr,
    input  logic        IorD,
    input  logic [31:0] PC,
    input  logic [31:0] ALUOut,
    input  logic [31:0] WData,
    input  logic [31:0] MemRData,
    output logic [31:0] MemAddr,
    output logic        MemWr,
    output logic [31:0] MemWData,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic [31:0] IR,
    output logic [31:0] MDR,
    output logic [5:0]  Op,
    output logic [5:0]  Funct,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [15:0] Imm16
);

    generate
        if (LAT < 1 || LAT > LAT_MAX) begin : g_lat_check
            $error("mem_sequencer: LAT must be within 1..15");
        end
    endgenerate

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_wr;
    logic        r_iord;
    logic [31:0] r_ir;
    logic [31:0] r_mdr;

    logic [31:0] w_req_addr;
    logic        w_accept;
    logic        w_cnt_is_one;
    logic        w_busy;
    logic        w_done;
    logic        w_err;
    logic        w_mem_wr;
    logic        w_capture;

    assign w_req_addr = IorD ? ALUOut : PC;
    assign w_accept   = (r_state == ST_IDLE) && Req;

    mem_seq_counter u_counter (
        .Clk          (Clk),
        .Reset_signal (Reset_signal),
        .load         (w_accept),
        .en           (r_state == ST_WAIT),
        .load_val     (CNT_W'(LAT)),
        .is_one       (w_cnt_is_one)
    );

    always_ff @(posedge Clk or negedge Reset_signal) begin
        if (!Reset_signal) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (Req) begin
                    if (!is_word_aligned(w_req_addr)) begin
                        w_next_state = ST_FAULT;
                    end else if (Wr) begin
                        w_next_state = ST_WRITE;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT:    if (w_cnt_is_one) w_next_state = ST_CAPTURE;
            ST_CAPTURE: w_next_state = ST_DONE;
            ST_WRITE:   w_next_state = ST_DONE;
            ST_FAULT:   w_next_state = ST_IDLE;
            ST_DONE:    w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_err     = 1'b0;
        w_mem_wr  = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            ST_WAIT: begin
                w_busy = 1'b1;
            end
            ST_CAPTURE: begin
                w_busy    = 1'b1;
                w_capture = 1'b1;
            end
            ST_WRITE: begin
                w_busy   = 1'b1;
                w_mem_wr = r_wr;
            end
            ST_FAULT: begin
                w_busy = 1'b1;
                w_done = 1'b1;
                w_err  = 1'b1;
            end
            ST_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Request attributes are frozen at accept so the datapath may move on
    always_ff @(posedge Clk or negedge Reset_signal) begin
        if (!Reset_signal) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
            r_iord  <= 1'b0;
            r_ir    <= '0;
            r_mdr   <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= w_req_addr;
                r_wdata <= WData;
                r_wr    <= Wr;
                r_iord  <= IorD;
            end
            if (w_capture) begin
                if (r_iord) begin
                    r_mdr <= MemRData;
                end else begin
                    r_ir  <= MemRData;
                end
            end
        end
    end

    assign MemAddr  = r_addr;
    assign MemWData = r_wdata;
    assign MemWr    = w_mem_wr;
    assign Busy     = w_busy;
    assign Done     = w_done;
    assign Err      = w_err;
    assign IR       = r_ir;
    assign MDR      = r_mdr;

    assign Op    = r_ir[OP_HI:OP_LO];
    assign Rs    = r_ir[RS_HI:RS_LO];
    assign Rt    = r_ir[RT_HI:RT_LO];
    assign Rd    = r_ir[RD_HI:RD_LO];
    assign Imm16 = r_ir[IMM_HI:IMM_LO];
    assign Funct = r_ir[FUNCT_HI:FUNCT_LO];

endmodule
`default_nettype wire

// File: tb/tb_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_sequencer
//  Description : Scoreboard bench for mem_sequencer (LAT=2 main, LAT=1 b2b).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_sequencer;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset_signal;
    logic        Req, Wr, IorD;
    logic [31:0] PC, ALUOut, WData, MemRData;
    logic [31:0] MemAddr, MemWData, IR, MDR;
    logic        MemWr, Busy, Done, Err;
    logic [5:0]  Op, Funct;
    logic [4:0]  Rs, Rt, Rd;
    logic [15:0] Imm16;

    logic        Req_b;
    logic        Wr_b   = 1'b0;
    logic        IorD_b = 1'b0;
    logic [31:0] PC_b;
    logic [31:0] ALUOut_b = 32'h0;
    logic [31:0] WData_b  = 32'h0;
    logic [31:0] MemRData_b, MemAddr_b, MemWData_b, IR_b, MDR_b;
    logic        MemWr_b, Busy_b, Done_b, Err_b;
    logic [5:0]  Op_b, Funct_b;
    logic [4:0]  Rs_b, Rt_b, Rd_b;
    logic [15:0] Imm16_b;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        case (a)
            32'h4:   return 32'h8C22_0008;
            32'h8:   return 32'h014B_4820;
            32'h10:  return 32'h1234_5678;
            default: return 32'hBAD0_0000;
        endcase
    endfunction

    assign MemRData   = mem_model(MemAddr);
    assign MemRData_b = mem_model(MemAddr_b);

    mem_sequencer #(.LAT(2)) u_dut (
        .Clk(Clk), .Reset_signal(Reset_signal), .Req(Req), .Wr(Wr), .IorD(IorD),
        .PC(PC), .ALUOut(ALUOut), .WData(WData), .MemRData(MemRData),
        .MemAddr(MemAddr), .MemWr(MemWr), .MemWData(MemWData), .Busy(Busy),
        .Done(Done), .Err(Err), .IR(IR), .MDR(MDR), .Op(Op), .Funct(Funct),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .Imm16(Imm16)
    );

    mem_sequencer #(.LAT(1)) u_dut_b (
        .Clk(Clk), .Reset_signal(Reset_signal), .Req(Req_b), .Wr(Wr_b), .IorD(IorD_b),
        .PC(PC_b), .ALUOut(ALUOut_b), .WData(WData_b), .MemRData(MemRData_b),
        .MemAddr(MemAddr_b), .MemWr(MemWr_b), .MemWData(MemWData_b), .Busy(Busy_b),
        .Done(Done_b), .Err(Err_b), .IR(IR_b), .MDR(MDR_b), .Op(Op_b), .Funct(Funct_b),
        .Rs(Rs_b), .Rt(Rt_b), .Rd(Rd_b), .Imm16(Imm16_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ir;
        logic [31:0] mdr;
        logic        err;
        int          strobes;
        int          done_cyc;
    } exp_t;

    typedef struct {
        logic [31:0] ir;
        int          done_cyc;
    } exp_b_t;

    exp_t   sb[$];
    exp_b_t sb_b[$];
    int     wr_seen = 0;
    int     done_b_cnt = 0;

    function automatic exp_t mk(input logic [31:0] addr, wdata, ir, mdr,
                                input logic err, input int strobes);
        exp_t e;
        e.addr = addr; e.wdata = wdata; e.ir = ir; e.mdr = mdr;
        e.err = err; e.strobes = strobes; e.done_cyc = 0;
        return e;
    endfunction

    always @(negedge Clk) begin : mon
        exp_t e;
        if (Reset_signal) begin
            if (MemWr) begin
                wr_seen++;
                if (sb.size() == 0) chk("unexpected_write", 32'(MemWr), 32'h0);
                else begin
                    chk("wr_addr", MemAddr, sb[0].addr);
                    chk("wr_data", MemWData, sb[0].wdata);
                end
            end
            if (Busy && sb.size() > 0) chk("busy_addr", MemAddr, sb[0].addr);
            if (Done) begin
                if (sb.size() == 0) chk("unexpected_done", 32'(Done), 32'h0);
                else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("err", 32'(Err), 32'(e.err));
                    chk("ir", IR, e.ir);
                    chk("mdr", MDR, e.mdr);
                    chk("wr_strobes", wr_seen, e.strobes);
                end
                wr_seen = 0;
            end else if (Err) begin
                chk("err_without_done", 32'(Err), 32'h0);
            end
        end
    end

    always @(negedge Clk) begin : mon_b
        exp_b_t eb;
        if (Reset_signal) begin
            if (MemWr_b || Err_b) chk("b_wr_or_err", 32'({MemWr_b, Err_b}), 32'h0);
            if (Done_b) begin
                done_b_cnt++;
                if (sb_b.size() == 0) chk("b_unexpected_done", 32'(Done_b), 32'h0);
                else begin
                    eb = sb_b.pop_front();
                    chk("b_done_cycle", cyc, eb.done_cyc);
                    chk("b_ir", IR_b, eb.ir);
                    chk("b_busy_at_done", 32'(Busy_b), 32'h0);
                end
            end
        end
    end

    // done_after: edges from the accepting edge to the Done edge
    task automatic issue(input logic wr, input logic iord, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input exp_t e, input int done_after);
        @(negedge Clk);
        Req = 1'b1; Wr = wr; IorD = iord; PC = pc; ALUOut = alu; WData = wd;
        e.done_cyc = cyc + 1 + done_after;
        sb.push_back(e);
        @(negedge Clk);
        Req = 1'b0;
        repeat (6) @(negedge Clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(Busy),  32'h0);
        chk({tag, "_done"},  32'(Done),  32'h0);
        chk({tag, "_err"},   32'(Err),   32'h0);
        chk({tag, "_memwr"}, 32'(MemWr), 32'h0);
        chk({tag, "_addr"},  MemAddr,    32'h0);
        chk({tag, "_wdata"}, MemWData,   32'h0);
        chk({tag, "_ir"},    IR,         32'h0);
        chk({tag, "_mdr"},   MDR,        32'h0);
    endtask

    initial begin
        Reset_signal = 1'b0;
        Req = 1'b0; Wr = 1'b0; IorD = 1'b0;
        PC = 32'h0; ALUOut = 32'h0; WData = 32'h0;
        Req_b = 1'b0; PC_b = 32'h0;
        repeat (2) @(negedge Clk);
        chk_all_zero("reset");
        Reset_signal = 1'b1;

        // Instruction fetch: lw $2, 8($1)
        issue(1'b0, 1'b0, 32'h4, 32'h0, 32'h0,
              mk(32'h4, 32'h0, 32'h8C22_0008, 32'h0, 1'b0, 0), 3);
        chk("op_lw",  32'(Op),    32'h23);
        chk("rs_lw",  32'(Rs),    32'h1);
        chk("rt_lw",  32'(Rt),    32'h2);
        chk("imm_lw", 32'(Imm16), 32'h0008);

        // Data read into MDR
        issue(1'b0, 1'b1, 32'h4, 32'h10, 32'h0,
              mk(32'h10, 32'h0, 32'h8C22_0008, 32'h1234_5678, 1'b0, 0), 3);

        // Aligned store
        issue(1'b1, 1'b1, 32'h4, 32'h20, 32'hDEAD_BEEF,
              mk(32'h20, 32'hDEAD_BEEF, 32'h8C22_0008, 32'h1234_5678, 1'b0, 1), 1);

        // Misaligned store and misaligned fetch
        issue(1'b1, 1'b1, 32'h4, 32'h22, 32'hCAFE_F00D,
              mk(32'h22, 32'hCAFE_F00D, 32'h8C22_0008, 32'h1234_5678, 1'b1, 0), 0);
        issue(1'b0, 1'b0, 32'h6, 32'h0, 32'h0,
              mk(32'h6, 32'h0, 32'h8C22_0008, 32'h1234_5678, 1'b1, 0), 0);

        // Fetch R-type: add $9, $10, $11
        issue(1'b0, 1'b0, 32'h8, 32'h0, 32'h0,
              mk(32'h8, 32'h0, 32'h014B_4820, 32'h1234_5678, 1'b0, 0), 3);
        chk("op_add",    32'(Op),    32'h0);
        chk("rs_add",    32'(Rs),    32'd10);
        chk("rt_add",    32'(Rt),    32'd11);
        chk("rd_add",    32'(Rd),    32'd9);
        chk("funct_add", 32'(Funct), 32'h20);
        chk("imm_add",   32'(Imm16), 32'h4820);

        // Reset while in WAIT: no Done may follow
        @(negedge Clk);
        Req = 1'b1; Wr = 1'b0; IorD = 1'b0; PC = 32'h10;
        @(negedge Clk);
        Req = 1'b0;
        @(negedge Clk);
        chk("busy_before_reset", 32'(Busy), 32'h1);
        Reset_signal = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (2) @(negedge Clk);
        Reset_signal = 1'b1;
        repeat (4) @(negedge Clk);

        issue(1'b0, 1'b0, 32'h4, 32'h0, 32'h0,
              mk(32'h4, 32'h0, 32'h8C22_0008, 32'h0, 1'b0, 0), 3);

        // Back-to-back fetches with Req held high, LAT=1: accepts 4 edges apart
        @(negedge Clk);
        Req_b = 1'b1; PC_b = 32'h4;
        sb_b.push_back('{ir: 32'h8C22_0008, done_cyc: cyc + 1 + 2});
        sb_b.push_back('{ir: 32'h014B_4820, done_cyc: cyc + 1 + 6});
        @(negedge Clk);
        PC_b = 32'h8;
        repeat (4) @(negedge Clk);
        Req_b = 1'b0;
        repeat (6) @(negedge Clk);
        chk("b_done_count", done_b_cnt, 2);
        chk("b_mdr",   MDR_b,          32'h0);
        chk("b_wdata", MemWData_b,     32'h0);
        chk("b_op",    32'(Op_b),      32'h0);
        chk("b_rs",    32'(Rs_b),      32'd10);
        chk("b_rt",    32'(Rt_b),      32'd11);
        chk("b_rd",    32'(Rd_b),      32'd9);
        chk("b_funct", 32'(Funct_b),   32'h20);
        chk("b_imm",   32'(Imm16_b),   32'h4820);

        chk("sb_drained",   sb.size(),   0);
        chk("sb_b_drained", sb_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
